// File: rtl/uart_pkg.sv
// Shared UART types: receiver bit-level state and the consumer request state.
package uart_pkg;

    // Receiver framing states used by the upstream UART receive stage.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Consumer request FSM: REQ_IDLE -> busy=0, REQ_WAIT -> busy=1.
    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } req_state_t;

    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/rx_byte_buffer_if.sv
// Byte-buffer bus: UART byte input, consumer request/response, status.
//   byte_valid/byte_in : received byte strobe and data
//   start/busy/data_out: consumer request handshake and delivered byte
//   count/cts_n/overflow/clr_ovf: fill level, flow control, sticky drop flag
interface rx_byte_buffer_if #(
    parameter int unsigned DEPTH = 16
);
    import uart_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_in;
    logic              start;
    logic              busy;
    logic [BYTE_W-1:0] data_out;
    logic [CW-1:0]     count;
    logic              cts_n;
    logic              overflow;
    logic              clr_ovf;

    // Driver side: UART stage plus consumer.
    modport master (
        output byte_valid, byte_in, start, clr_ovf,
        input  busy, data_out, count, cts_n, overflow
    );

    // Buffer side.
    modport slave (
        input  byte_valid, byte_in, start, clr_ovf,
        output busy, data_out, count, cts_n, overflow
    );
endinterface

// File: rtl/rx_byte_buffer_byte_fifo.sv
// Circular byte FIFO with wrapping pointers and an occupancy counter.
//   push/din  : write din at the tail (caller guarantees room or same-cycle pop)
//   pop/dout  : dout always shows the head; pop advances past it
//   count     : bytes stored; full/empty decoded from count
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BYTE_W-1:0]          din,
    output logic [BYTE_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; empty slots are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/rx_byte_buffer.sv
// UART receive byte buffer: FIFO with request FSM, empty-FIFO bypass,
// sticky overflow and registered clear-to-send.
//   clk, rst : clock, async active-high reset
//   bus      : rx_byte_buffer_if slave (byte in, start/busy/data_out, status)
module rx_byte_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CTS_MARGIN = 4
) (
    input  logic               clk,
    input  logic               rst,
    rx_byte_buffer_if.slave    bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    req_state_t        state_q, state_d;
    logic              busy_q, busy_d;
    logic [BYTE_W-1:0] data_out_q, data_out_d;
    logic              overflow_q, overflow_d;
    logic              cts_n_q, cts_n_d;

    logic              push_c, pop_c, bypass_c, drop_c;
    logic [CW-1:0]     count_nxt_c;
    logic [BYTE_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (bus.byte_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Request FSM, delivery mux, push/drop decision, status next-state.
    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        pop_c      = 1'b0;
        bypass_c   = 1'b0;

        case (state_q)
            REQ_IDLE: begin
                if (bus.start) begin
                    state_d = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (!fifo_empty) begin
                    pop_c      = 1'b1;
                    data_out_d = fifo_dout;
                    state_d    = REQ_IDLE;
                end else if (bus.byte_valid) begin
                    // Empty FIFO: hand the arriving byte straight to the consumer.
                    bypass_c   = 1'b1;
                    data_out_d = bus.byte_in;
                    state_d    = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase

        // A same-cycle pop frees the slot, so a full FIFO can still accept.
        push_c = bus.byte_valid && !bypass_c && (!fifo_full || pop_c);
        drop_c = bus.byte_valid && !bypass_c && fifo_full && !pop_c;

        count_nxt_c = fifo_count + CW'(push_c) - CW'(pop_c);

        busy_d = (state_d == REQ_WAIT);

        // A drop wins over a simultaneous clear.
        if (drop_c) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        cts_n_d = (count_nxt_c >= CW'(DEPTH - CTS_MARGIN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= REQ_IDLE;
            busy_q     <= 1'b0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
            cts_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            overflow_q <= overflow_d;
            cts_n_q    <= cts_n_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.data_out = data_out_q;
    assign bus.count    = fifo_count;
    assign bus.cts_n    = cts_n_q;
    assign bus.overflow = overflow_q;

endmodule

// File: doc/rx_byte_buffer.md
RX_BYTE_BUFFER -- requirements
Module: rx_byte_buffer

Interface
REQ-001 Parameter DEPTH, default 16, shall set FIFO capacity in bytes; legal values are powers of two from 2 to 256.
REQ-002 Parameter CTS_MARGIN, default 4, shall set the free-slot threshold for flow control; legal range is 1 to DEPTH-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 byte_valid  input  1  one-cycle pulse from the free-running UART receive stage: byte_in is valid this cycle.
REQ-006 byte_in  input  8  received byte.
REQ-007 start  input  1  consumer request for the next byte; honoured only while busy=0.
REQ-008 busy  output  1  high while a request is pending; falls on the cycle data_out is updated.
REQ-009 data_out  output  8  last delivered byte; holds its value until the next delivery.
REQ-010 count  output  $clog2(DEPTH)+1  number of bytes currently stored.
REQ-011 cts_n  output  1  active-low clear-to-send, registered.
REQ-012 overflow  output  1  sticky flag: a byte was dropped.
REQ-013 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-014 Storage shall be a circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and count of $clog2(DEPTH)+1 bits.
REQ-015 Request FSM shall have two states: IDLE (busy=0) and WAIT (busy=1).
REQ-016 IDLE plus start shall move to WAIT, so busy is high on the next cycle; start is ignored in WAIT.
REQ-017 WAIT with count>0 shall pop the head into data_out and return to IDLE in the same edge, so a nonempty-FIFO request completes 2 cycles after start.
REQ-018 WAIT with count==0 and byte_valid=1 shall bypass byte_in directly to data_out, return to IDLE, and leave the FIFO unchanged.
REQ-019 WAIT with count==0 and byte_valid=0 shall remain in WAIT indefinitely.
REQ-020 byte_valid outside the bypass case shall push byte_in when count<DEPTH, or when a pop occurs on the same cycle.
REQ-021 A push and a pop on the same cycle shall leave count unchanged; the popped byte shall be the old head, never byte_in, unless count==0 (bypass rule applies).
REQ-022 byte_valid while count==DEPTH with no same-cycle pop shall drop the byte, leave all pointers unchanged, and set overflow.
REQ-023 clr_ovf shall clear overflow next cycle; clr_ovf and a drop on the same cycle shall leave overflow=1.
REQ-024 cts_n shall be set to 1 when next-cycle count >= DEPTH-CTS_MARGIN, else 0, updated one cycle after the count change.
REQ-025 Contents of empty slots are don't-care; data_out shall never change except on pop or bypass.

Reset
REQ-026 rst=1 shall immediately force: state IDLE, busy 0, data_out 8'h00, count 0, pointers 0, overflow 0, cts_n 1.
REQ-027 The first edge after rst deasserts shall set cts_n to 0; a pending request or stored bytes at reset time shall be discarded.
REQ-028 Storage array contents need not be reset.

Structure
REQ-029 The request-state enum (IDLE, WAIT) shall reside in shared package uart_pkg alongside the receiver state enum.
REQ-030 The circular buffer shall be a sub-module byte_fifo (push, pop, din, dout, count, full, empty); the request FSM, bypass, overflow and cts_n logic shall be in rx_byte_buffer.

Verification
REQ-031 Push 8'hA5 and 8'h3C, then start -> busy 1 for one cycle; data_out 8'hA5 at start+2; count 1.
REQ-032 Empty FIFO, start, wait 10 cycles, then byte_valid with 8'h55 -> data_out 8'h55 and busy 0 on the next edge; count stays 0.
REQ-033 DEPTH=16, CTS_MARGIN=4: push 12 bytes -> cts_n goes 1 one cycle after the 12th push; pop one byte -> cts_n returns to 0.
REQ-034 Fill 16 bytes, push 8'hFF -> byte dropped, overflow 1, count 16; issue 16 requests -> the original bytes come out in order; clr_ovf -> overflow 0.
REQ-035 With FIFO full and WAIT active, byte_valid 8'h77 on the pop cycle -> head is delivered, 8'h77 is stored last, count stays 16, overflow stays 0.
REQ-036 Assert rst mid-WAIT with 5 bytes stored -> busy 0, count 0, cts_n 1 immediately; cts_n 0 one edge after release.
